// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU MAC processing element.
//   TPU_BITS_AB   default operand width
//   TPU_BITS_C    default accumulator width
//   TPU_MAX_C     widest accumulator the clamp helper can describe
//   tpu_sat_limit clamp value for a w-bit accumulator (signed/unsigned, high/low)
package tpu_pkg;

  localparam int TPU_BITS_AB = 8;
  localparam int TPU_BITS_C  = 24;
  localparam int TPU_MAX_C   = 64;

  // Returns the saturation bound in the low w bits.
  //   sgn=0: all-ones, or 0 for an underflow (cannot happen when unsigned)
  //   sgn=1: max positive, or most-negative when under=1
  function automatic logic [TPU_MAX_C-1:0] tpu_sat_limit(input int unsigned w,
                                                        input logic sgn,
                                                        input logic under);
    logic [TPU_MAX_C-1:0] ones;
    ones = '1;
    ones = ones >> (TPU_MAX_C - w);
    if (!sgn) return under ? '0 : ones;
    // signed min is the top bit alone; signed max is every bit below it
    return under ? (ones ^ (ones >> 1)) : (ones >> 1);
  endfunction

endpackage

// File: rtl/tpu_mul_stage.sv
// Stage 1 of the MAC: operand multiply plus product register. Kept on its own
// so a vendor DSP primitive can drop in here.
//   a_i, b_i        operands (BITS_AB)
//   mode_signed_i   1 = two's-complement operands
//   valid_i         operand pair is real
//   en_i            advance; low holds every register
//   p_o             registered 2*BITS_AB-bit product
//   p_vld_o         registered valid
//   p_sgn_o         mode sampled with the operands
module tpu_mul_stage import tpu_pkg::*; #(
  parameter int BITS_AB = TPU_BITS_AB
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   mode_signed_i,
  input  logic                   valid_i,
  input  logic [BITS_AB-1:0]     a_i,
  input  logic [BITS_AB-1:0]     b_i,
  output logic [2*BITS_AB-1:0]   p_o,
  output logic                   p_vld_o,
  output logic                   p_sgn_o
);

  localparam int PW = 2 * BITS_AB;

  // Extending both operands to the product width first makes the low PW
  // bits of the product exact for both signed and unsigned inputs.
  logic [PW-1:0] a_x, b_x, prod;
  logic [PW-1:0] p_q;
  logic          p_vld_q, p_sgn_q;

  assign a_x  = mode_signed_i ? PW'($signed(a_i)) : PW'(a_i);
  assign b_x  = mode_signed_i ? PW'($signed(b_i)) : PW'(b_i);
  assign prod = a_x * b_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      p_vld_q <= 1'b0;
      p_sgn_q <= 1'b0;
    end else if (en_i) begin
      p_q     <= prod;
      p_vld_q <= valid_i;
      p_sgn_q <= mode_signed_i;
    end
  end

  assign p_o     = p_q;
  assign p_vld_o = p_vld_q;
  assign p_sgn_o = p_sgn_q;

endmodule

// File: rtl/tpu_mac_pe.sv
// Systolic MAC processing element: forwards A/B to neighbours, multiplies in
// stage 1 (tpu_mul_stage), accumulates with optional saturation in stage 2.
//   Ain/Bin/valid_in   operands in       Aout/Bout/valid_out  1-cycle forward
//   mode_signed        operand signedness, travels with the product
//   en                 advance; low holds all pipeline registers
//   clr / WrEn, Cin    clear / preload accumulator (act even when en=0)
//   Cout, ovf          accumulator, sticky overflow flag
module tpu_mac_pe import tpu_pkg::*; #(
  parameter int BITS_AB  = TPU_BITS_AB,
  parameter int BITS_C   = TPU_BITS_C,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               mode_signed,
  input  logic               valid_in,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  input  logic               WrEn,
  input  logic [BITS_C-1:0]  Cin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic               valid_out,
  output logic [BITS_C-1:0]  Cout,
  output logic               ovf
);

  localparam int PW = 2 * BITS_AB;

  if (BITS_C < PW || BITS_C > TPU_MAX_C) begin : g_bad_width
    $error("tpu_mac_pe: BITS_C must lie between 2*BITS_AB and TPU_MAX_C");
  end

  logic [BITS_AB-1:0] a_q, b_q;
  logic               vld_q;
  logic [PW-1:0]      p;
  logic               p_vld, p_sgn;
  logic [BITS_C-1:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d;

  tpu_mul_stage #(.BITS_AB(BITS_AB)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .mode_signed_i(mode_signed),
    .valid_i      (valid_in),
    .a_i          (Ain),
    .b_i          (Bin),
    .p_o          (p),
    .p_vld_o      (p_vld),
    .p_sgn_o      (p_sgn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      a_q   <= Ain;
      b_q   <= Bin;
      vld_q <= valid_in;
    end
  end

  // One extra bit on the sum: in signed mode overflow shows as the two top
  // bits disagreeing (top bit is the true sign); unsigned mode it is carry-out.
  logic [BITS_C-1:0] p_ext;
  logic [BITS_C:0]   sum;
  logic              ovf_hit;
  logic [BITS_C-1:0] clamp;

  assign p_ext   = p_sgn ? BITS_C'($signed(p)) : BITS_C'(p);
  assign sum     = {p_sgn & acc_q[BITS_C-1], acc_q} + {p_sgn & p_ext[BITS_C-1], p_ext};
  assign ovf_hit = p_sgn ? (sum[BITS_C] ^ sum[BITS_C-1]) : sum[BITS_C];
  assign clamp   = BITS_C'(tpu_sat_limit(BITS_C, p_sgn, p_sgn & sum[BITS_C]));

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (WrEn) begin
      acc_d = Cin;
      ovf_d = 1'b0;
    end else if (en && p_vld) begin
      acc_d = sum[BITS_C-1:0];
      if (ovf_hit) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) acc_d = clamp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Aout      = a_q;
  assign Bout      = b_q;
  assign valid_out = vld_q;
  assign Cout      = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/tpu_mac_pe.md
TPU_MAC_PE -- requirements
Module: tpu_mac_pe

Interface
REQ-001 SHALL have parameter BITS_AB, default 8: width of the A and B operands.
REQ-002 SHALL have parameter BITS_C, default 24: accumulator width; elaboration SHALL fail if BITS_C < 2*BITS_AB.
REQ-003 SHALL have parameter SATURATE, default 1: 1 = accumulator clamps on overflow, 0 = accumulator wraps.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  global advance; when low, every register holds.
REQ-007 clr  input  1  synchronous accumulator and overflow-flag clear.
REQ-008 mode_signed  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 valid_in  input  1  Ain/Bin carry a real operand pair this cycle.
REQ-010 Ain, Bin  input  BITS_AB  operands.
REQ-011 WrEn  input  1  load Cin into the accumulator.
REQ-012 Cin  input  BITS_C  accumulator preload value.
REQ-013 Aout, Bout  output  BITS_AB  registered operand forward to the neighbouring PE.
REQ-014 valid_out  output  1  registered valid_in, aligned with Aout/Bout.
REQ-015 Cout  output  BITS_C  accumulator value.
REQ-016 ovf  output  1  sticky overflow flag.

Function
REQ-017 When en=1, Aout/Bout/valid_out SHALL capture Ain/Bin/valid_in: 1-cycle forward latency, independent of valid_in.
REQ-018 Stage 1: when en=1, product register P SHALL capture Ain*Bin as a 2*BITS_AB-bit product (sign-extended if mode_signed=1, else zero-extended), and P_vld SHALL capture valid_in.
REQ-019 mode_signed SHALL be sampled into stage 1 with the operands; stage 2 uses the sampled mode, so mode may change every cycle.
REQ-020 Stage 2: when en=1 and P_vld=1, the accumulator SHALL add P, extended to BITS_C per the sampled mode; Cout reflects a product 2 cycles after its operands are presented.
REQ-021 Overflow SHALL be evaluated on a BITS_C+1-bit sum, against the signed range when the sampled mode is signed and the unsigned range otherwise.
REQ-022 On overflow with SATURATE=1, the accumulator SHALL clamp: signed mode to the max/min signed value, unsigned mode to all-ones (or 0 on underflow, which is impossible in unsigned mode).
REQ-023 On overflow with SATURATE=0, the accumulator SHALL keep the low BITS_C bits (wrap).
REQ-024 On any overflow, ovf SHALL be set and SHALL stay set until cleared.
REQ-025 Accumulator update priority: clr (load 0, clear ovf) > WrEn (load Cin, clear ovf) > accumulate.
REQ-026 clr and WrEn SHALL act regardless of en; a product in stage 2 in the same cycle SHALL be discarded.
REQ-027 When en=0, P and P_vld SHALL hold, so a pending product accumulates on the next en=1 cycle; no product is lost or duplicated.
REQ-028 valid_in=0 bubbles SHALL leave the accumulator unchanged.

Reset
REQ-029 On rst_n low, the block SHALL immediately clear Aout, Bout, valid_out, P, P_vld, Cout and ovf to 0, including mid-pipeline; the pending product is discarded.
REQ-030 The first clock edge after reset release SHALL behave as a normal cycle.

Structure
REQ-031 Shared package tpu_pkg SHALL hold the default widths (TPU_BITS_AB, TPU_BITS_C) and the saturation-clamp helper function.
REQ-032 Stage 1 SHALL be one sub-module, tpu_mul_stage (signed/unsigned multiply plus P/P_vld/mode register), so it can be replaced by a vendor DSP block; accumulate, saturate and forwarding logic stay in tpu_mac_pe.

Verification
REQ-033 Signed accumulate: Ain=-3, Bin=5 at t0, then Ain=7, Bin=2 at t1 -> Cout=-15 at t0+2, Cout=-1 at t0+3, ovf=0.
REQ-034 Unsigned mode: Ain=255, Bin=255 -> Cout=65025, not 1.
REQ-035 Saturation: WrEn with Cin=0x7FFFF0, then signed 16*16 -> with SATURATE=1 Cout=0x7FFFFF and ovf=1; with SATURATE=0 Cout=0x8000F0 and ovf=1.
REQ-036 Simultaneous events: WrEn Cin=100 in the same cycle a product of 6 reaches stage 2 -> Cout=100; clr+WrEn together -> Cout=0, ovf=0.
REQ-037 Stall: operands 2*3, en low for 3 cycles after stage 1 capture -> Cout stays 0 during the stall, then becomes 6 exactly once after en rises; Aout holds during the stall.
REQ-038 Reset mid-pipeline: rst_n pulsed while P_vld=1 -> all outputs 0 asynchronously, and the product never appears in Cout.
